// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file at the write-back end.
//
// Purpose:
//   Takes the registered write-back triple (wb_wreg, wb_wd, wb_wdata) from
//   MEM/WB and serves two combinational decode read ports. A write in the
//   same cycle is forwarded to a read of the same register. A pending-write
//   scoreboard tracks late-arriving results (loads) so that decode can stall
//   until the producing write-back retires. Entry x0 always reads as zero.
//
// Ports:
//   clk              core clock, rising-edge state updates
//   rst              asynchronous reset, active low
//   wb_wreg/wb_wd/wb_wdata   write-back enable / destination / data
//   re1/raddr1/rdata1        read port 1 enable / address / data
//   re2/raddr2/rdata2        read port 2 enable / address / data
//   sb_set/sb_addr           mark sb_addr as having a pending write
//   busy1/busy2              read address has a pending write not retiring now
//
// Optional build macro REGFILE_DEBUG_PORT_EN:
//   adds dbg_raddr/dbg_rdata, an unbypassed, always-enabled read port for
//   the debug path (returns 0 for x0 and while in reset).

// Per-read-port select/bypass/hazard logic.
module wb_regfile_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] reg_q,    // regs[raddr]
  input  logic              pend_q,   // pend[raddr]
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  logic active;
  logic hit;

  // Reset, disabled port and x0 all force zero; nothing else may leak out.
  assign active = rst && re && (raddr != '0);
  assign hit    = wb_wreg && (wb_wd == raddr);

  always_comb begin
    rdata = '0;
    if (active) rdata = hit ? wb_wdata : reg_q;
  end

  // A pending register that retires this cycle is served by the bypass,
  // so it does not stall decode.
  assign busy = active && pend_q && !hit;
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);
  localparam int NRD = 2;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             pend;

  logic [NRD-1:0]             re;
  logic [NRD-1:0][ADDR_W-1:0] raddr;
  logic [NRD-1:0][DATA_W-1:0] rdata;
  logic [NRD-1:0]             busy;

  logic wr_en;
  logic set_en;

  assign wr_en  = wb_wreg && (wb_wd != '0);
  assign set_en = sb_set && (sb_addr != '0);

  // regs[0] is only ever cleared, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       regs        <= '0;
    else if (wr_en) regs[wb_wd] <= wb_wdata;
  end

  // Set is issued after clear so that, on the same address, the later
  // non-blocking assignment (set) wins: the new producer supersedes the
  // retiring one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      if (wr_en)  pend[wb_wd]   <= 1'b0;
      if (set_en) pend[sb_addr] <= 1'b1;
    end
  end

  assign re    = {re2, re1};
  assign raddr = {raddr2, raddr1};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    wb_regfile_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .rst      (rst),
      .re       (re[g]),
      .raddr    (raddr[g]),
      .reg_q    (regs[raddr[g]]),
      .pend_q   (pend[raddr[g]]),
      .wb_wreg  (wb_wreg),
      .wb_wd    (wb_wd),
      .wb_wdata (wb_wdata),
      .rdata    (rdata[g]),
      .busy     (busy[g])
    );
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];
  assign busy1  = busy[0];
  assign busy2  = busy[1];

`ifdef REGFILE_DEBUG_PORT_EN
  // Architectural state only: no bypass, so debug sees committed values.
  assign dbg_rdata = (!rst || dbg_raddr == '0) ? '0 : regs[dbg_raddr];
`endif
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file at the consumer end of the write-back path.
- Accepts the registered write-back triple (dest address, write enable, data) from the MEM/WB stage register.
- Serves two decode-stage read ports, with same-cycle write-to-read bypass.
- Keeps a pending-write scoreboard so decode can detect load-use / long-latency hazards until the producing write-back retires.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers (2**ADDR_W); entry 0 is hardwired zero.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active low (reset asserted when rst==0, acts on negedge rst).
- wb_wreg  input  1  write-back enable.
- wb_wd  input  ADDR_W  write-back destination register.
- wb_wdata  input  DATA_W  write-back data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data.
- sb_set  input  1  decode issues an instruction whose result arrives late (load); mark destination pending.
- sb_addr  input  ADDR_W  destination to mark pending.
- busy1  output  1  raddr1 has a pending write not retiring this cycle.
- busy2  output  1  raddr2 likewise for port 2.

Behaviour:
- Reset (rst==0, async): all NREGS entries cleared to 0; scoreboard cleared. rdata1/rdata2 = 0 and busy1/busy2 = 0 while reset asserted, regardless of other inputs.
- Write: on posedge clk, if wb_wreg==1 and wb_wd!=0, regs[wb_wd] <= wb_wdata. Writes to x0 are discarded.
- Read (combinational, zero latency), per port n, in priority order:
  - rdata = 0 if rst==0, or re==0, or raddr==0.
  - Else rdata = wb_wdata if wb_wreg==1 and wb_wd==raddr (bypass: write-first).
  - Else rdata = regs[raddr].
- Both ports may read the same address; both see identical data.
- Scoreboard: one pending bit per register, bit 0 tied 0.
  - Clear: posedge with wb_wreg==1 and wb_wd!=0 clears bit[wb_wd].
  - Set: posedge with sb_set==1 and sb_addr!=0 sets bit[sb_addr].
  - Same address set and cleared in the same cycle: set wins, so the bit stays 1 (a new producer supersedes the retiring one).
- busyn = re_n & (raddr_n!=0) & pend[raddr_n] & ~(wb_wreg & wb_wd==raddr_n). A pending register being written this cycle is not busy, because bypass supplies the data.
- sb_set with sb_addr==0 has no effect. Setting an already-pending bit is idempotent; no counting or overflow.
- Reset asserted mid-operation: the array and scoreboard clear immediately; the first posedge after rst rises performs a normal write/set.
- No X propagation: unused read ports return 0.

Optional Feature:
- Macro REGFILE_DEBUG_PORT_EN.
- When defined, adds ports dbg_raddr (input ADDR_W) and dbg_rdata (output DATA_W): a third combinational read port with no enable and no bypass. It returns regs[dbg_raddr] (0 for x0 or during reset) and is used by the debug/JTAG path to inspect architectural state.
- When undefined, these ports do not exist and logic is unchanged otherwise.

Test Plan:
- Reset then read: rst=0 pulse; re1=1 raddr1=5 -> rdata1=0x00000000, busy1=0.
- Write then read: write wb_wd=3, wb_wdata=0xDEADBEEF, wb_wreg=1 for one cycle; next cycle raddr1=3, raddr2=3 -> both ports 0xDEADBEEF.
- Bypass: same cycle wb_wreg=1, wb_wd=7, wb_wdata=0x12345678, re2=1, raddr2=7 -> rdata2=0x12345678 before the edge; after the edge it holds with wb_wreg=0.
- x0 protection: write wb_wd=0, wb_wdata=0xFFFFFFFF; read raddr1=0 (same and next cycle) -> rdata1=0; sb_set with sb_addr=0 -> busy1=0.
- Scoreboard: sb_set=1, sb_addr=9; next cycle raddr1=9 -> busy1=1. Then wb_wreg=1, wb_wd=9, wb_wdata=0x55 -> busy1=0 that cycle, rdata1=0x55. After the edge, pending is clear.
- Set/clear collision: pend[4]=1; same cycle sb_set addr 4 and wb write to 4 (0xAA) -> next cycle busy for raddr=4 is 1 and regs[4]=0xAA. Assert rst=0 mid-sequence -> busy drops to 0 and rdata=0 immediately.
